core_v_mcu_rst_strap_ctrl: RTL and testbench
============================================

// Module: core_v_mcu_rst_strap_ctrl
// PURPOSE
//  Reset conditioner and boot-strap latch between FPGA pad buffers and core_v_mcu.
//  Synchronises and debounces the raw reset pad, then holds reset for a fixed time.
//  Captures stm/bootsel straps once, at reset release, and keeps them frozen.
//  Drives core rstn_i/stm_i/bootsel_i; rst_ni comes from fpga_slow_clk_gen lock/power-on.
// PARAMETERS
//  SYNC_STAGES      2     flops per synchroniser (pad rstn, stm, bootsel); >=2
//  DEBOUNCE_CYCLES  1024  consecutive equal sync samples needed to accept a pad level; >=1
//  HOLD_CYCLES      256   extra reset cycles after strap capture; 0 = skip HOLD
//  CNT_W  $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES)+1)  localparam, shared counter width
// PORTS
//  clk_i          in   1  reference clock (s_ref_clk domain)
//  rst_ni         in   1  async active-low reset (clock-gen lock / power-on)
//  pad_rstn_i     in   1  raw reset pad, asynchronous, may bounce
//  stm_pad_i      in   1  raw STM strap pad
//  bootsel_pad_i  in   1  raw boot-select strap pad
//  rstn_o         out  1  conditioned reset to core_v_mcu (registered)
//  stm_o          out  1  latched STM strap
//  bootsel_o      out  1  latched boot-select strap
//  rst_state_o    out  3  one-hot-free FSM state encoding, debug only
// BEHAVIOUR
//  Reset is asynchronous and active-low: clock clk_i, reset rst_ni.
//  rst_ni=0: rstn_o=0, stm_o=0, bootsel_o=0, all sync flops 0, cnt=0, state=ASSERT.
//  All three pads pass SYNC_STAGES-flop synchronisers; only sync outputs used below.
//  FSM states: ASSERT(0) WAIT(1) SAMPLE(2) HOLD(3) RUN(4); rstn_o=1 only in RUN.
//  ASSERT: cnt=0; sync pad=1 -> WAIT.
//  WAIT: sync pad=1 -> cnt++; sync pad=0 -> cnt=0, ->ASSERT; cnt reaching
//    DEBOUNCE_CYCLES -> SAMPLE, cnt=0.
//  SAMPLE (1 cycle): stm_o<=sync stm, bootsel_o<=sync bootsel; -> HOLD (RUN if HOLD=0).
//  HOLD: cnt++; cnt reaching HOLD_CYCLES -> RUN (rstn_o<=1 on that edge).
//  Release latency: rstn_o rises SYNC_STAGES+DEBOUNCE_CYCLES+1+HOLD_CYCLES edges after
//    the first edge sampling pad high (stable pad assumed).
//  RUN: sync pad=0 counts up; sync pad=1 clears cnt; DEBOUNCE_CYCLES consecutive
//    lows -> ASSERT, rstn_o<=0 same edge. Straps ignored in RUN.
//  Pad low during HOLD: cnt cleared, ->ASSERT immediately (rstn_o already 0).
//  Straps change only in SAMPLE; stm_o/bootsel_o keep values through ASSERT/WAIT/HOLD.
//  Pad low and cnt terminal on same edge: low wins (no forward transition).
//  Counter saturates, never wraps; rstn_o is glitch-free (single flop output).
// CONFIGURATION
//  CORE_V_MCU_RST_FAST_ASSERT_EN defined: in RUN a single sync pad=0 sample
//    -> ASSERT next edge (assert latency SYNC_STAGES+1); release path unchanged.
//  Not defined: assertion debounced as above (SYNC_STAGES+DEBOUNCE_CYCLES).
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4 unless stated)
//  Power-on: rst_ni low 3 cycles, pad=1 -> rstn_o/stm_o/bootsel_o=0 during reset;
//    rstn_o rises exactly 15 edges after rst_ni release.
//  Bounce: pad 1 for 5 cycles, 0 for 1, then 1 -> cnt restarts; rstn_o rises
//    15 edges after the final rising sample.
//  Straps: stm=1,bootsel=0 at SAMPLE, then toggle both in HOLD/RUN -> stm_o=1,
//    bootsel_o=0 held until next SAMPLE.
//  Run glitch: in RUN pad low 7 cycles -> rstn_o stays 1; low 8 cycles -> rstn_o=0
//    at edge 10 after first low (FAST_ASSERT_EN: edge 3 after 1-cycle low).
//  Mid-hold reset: pad low in HOLD cycle 2 -> state ASSERT next edge, rstn_o=0,
//    full 15-edge sequence required on next release.
//  HOLD_CYCLES=0: SAMPLE->RUN direct, rstn_o rises 11 edges after pad high.

Source files
------------

// File: rtl/core_v_mcu_rst_strap_ctrl.sv
// core_v_mcu_rst_strap_ctrl
//   Reset conditioner and boot-strap latch between the FPGA pad buffers and core_v_mcu.
//   The raw reset pad is synchronised and debounced. Reset is then held for a fixed time.
//   The stm/bootsel straps are captured once, at reset release, and stay frozen afterwards.
//
// Parameters
//   SYNC_STAGES      flops per synchroniser (>= 2)
//   DEBOUNCE_CYCLES  consecutive equal synchronised samples needed to accept a pad level (>= 1)
//   HOLD_CYCLES      extra reset cycles after strap capture (0 skips the hold phase)
//
// Ports
//   clk_i          reference clock
//   rst_ni         async active-low reset (clock-gen lock / power-on)
//   pad_rstn_i     raw reset pad, asynchronous, may bounce
//   stm_pad_i      raw STM strap pad
//   bootsel_pad_i  raw boot-select strap pad
//   rstn_o         conditioned reset to core_v_mcu (single flop output)
//   stm_o          latched STM strap
//   bootsel_o      latched boot-select strap
//   rst_state_o    FSM state for debug: 0 assert, 1 wait, 2 sample, 3 hold, 4 run
//
// Build option
//   CORE_V_MCU_RST_FAST_ASSERT_EN: in run, a single low synchronised pad sample re-asserts reset.
//   The release path does not change.

module core_v_mcu_rst_strap_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES     = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pad_rstn_i,
  input  logic       stm_pad_i,
  input  logic       bootsel_pad_i,
  output logic       rstn_o,
  output logic       stm_o,
  output logic       bootsel_o,
  output logic [2:0] rst_state_o
);

  localparam int unsigned CntMax = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                    : HOLD_CYCLES;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);

  localparam logic [CNT_W-1:0] DebTerm  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HoldTerm = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [2:0] {
    StAssert = 3'd0,
    StWait   = 3'd1,
    StSample = 3'd2,
    StHold   = 3'd3,
    StRun    = 3'd4
  } state_e;

  // Synchronisers: bit 0 samples the pad, the MSB is the only bit used downstream.
  logic [SYNC_STAGES-1:0] r_pad_sync;
  logic [SYNC_STAGES-1:0] r_stm_sync;
  logic [SYNC_STAGES-1:0] r_boot_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pad_sync  <= '0;
      r_stm_sync  <= '0;
      r_boot_sync <= '0;
    end else begin
      r_pad_sync  <= {r_pad_sync[SYNC_STAGES-2:0], pad_rstn_i};
      r_stm_sync  <= {r_stm_sync[SYNC_STAGES-2:0], stm_pad_i};
      r_boot_sync <= {r_boot_sync[SYNC_STAGES-2:0], bootsel_pad_i};
    end
  end

  logic w_pad;
  logic w_stm;
  logic w_boot;

  assign w_pad  = r_pad_sync[SYNC_STAGES-1];
  assign w_stm  = r_stm_sync[SYNC_STAGES-1];
  assign w_boot = r_boot_sync[SYNC_STAGES-1];

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rstn;
  logic             r_stm;
  logic             r_boot;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment, so the counter can never wrap back to a non-terminal value.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CntOne;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StAssert;
      r_cnt   <= '0;
      r_rstn  <= 1'b0;
      r_stm   <= 1'b0;
      r_boot  <= 1'b0;
    end else begin
      unique case (r_state)
        StAssert: begin
          r_rstn <= 1'b0;
          // The high sample seen here is the first of the debounce run.
          if (w_pad) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= StSample;
              r_cnt   <= '0;
            end else begin
              r_state <= StWait;
              r_cnt   <= CntOne;
            end
          end else begin
            r_cnt <= '0;
          end
        end

        StWait: begin
          // A low sample takes priority over a terminal count.
          if (!w_pad) begin
            r_state <= StAssert;
            r_cnt   <= '0;
          end else if (w_cnt_inc == DebTerm) begin
            r_state <= StSample;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StSample: begin
          r_stm  <= w_stm;
          r_boot <= w_boot;
          r_cnt  <= '0;
          if (!w_pad) begin
            r_state <= StAssert;
          end else if (HOLD_CYCLES == 0) begin
            r_state <= StRun;
            r_rstn  <= 1'b1;
          end else begin
            r_state <= StHold;
          end
        end

        StHold: begin
          if (!w_pad) begin
            r_state <= StAssert;
            r_cnt   <= '0;
          end else if (w_cnt_inc == HoldTerm) begin
            r_state <= StRun;
            r_rstn  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        StRun: begin
          if (!w_pad) begin
`ifdef CORE_V_MCU_RST_FAST_ASSERT_EN
            r_state <= StAssert;
            r_rstn  <= 1'b0;
            r_cnt   <= '0;
`else
            // The low run is debounced exactly like the release path.
            if (w_cnt_inc == DebTerm) begin
              r_state <= StAssert;
              r_rstn  <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
`endif
          end else begin
            r_cnt <= '0;
          end
        end

        default: begin
          r_state <= StAssert;
          r_rstn  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rstn_o      = r_rstn;
  assign stm_o       = r_stm;
  assign bootsel_o   = r_boot;
  assign rst_state_o = r_state;

endmodule

// File: tb/tb_core_v_mcu_rst_strap_ctrl.sv
module tb_core_v_mcu_rst_strap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pad;
  logic       stm;
  logic       bootsel;
  logic       rstn0, stm0, boot0;
  logic [2:0] state0;
  logic       rstn1, stm1, boot1;
  logic [2:0] state1;

  always #5 clk = ~clk;

  core_v_mcu_rst_strap_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (4)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pad_rstn_i   (pad),
    .stm_pad_i    (stm),
    .bootsel_pad_i(bootsel),
    .rstn_o       (rstn0),
    .stm_o        (stm0),
    .bootsel_o    (boot0),
    .rst_state_o  (state0)
  );

  // No hold phase: reset releases straight from sample.
  core_v_mcu_rst_strap_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (0)
  ) u_dut_nohold (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pad_rstn_i   (pad),
    .stm_pad_i    (stm),
    .bootsel_pad_i(bootsel),
    .rstn_o       (rstn1),
    .stm_o        (stm1),
    .bootsel_o    (boot1),
    .rst_state_o  (state1)
  );

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic push_exp(input string tag, input int exp);
    sb_q.push_back('{tag: tag, exp: exp});
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    if (sb_q.size() == 0) e = '{tag: "scoreboard_empty", exp: -2};
    else e = sb_q.pop_front();
    n_total++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
  endtask

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until rstn0 equals val, or -1 on timeout.
  task automatic wait_rstn(input logic val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (rstn0 === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    int  r0;
    int  r1;
    int  highs;
    bit  found;

    // Power-on: straps stm=1/bootsel=0 at capture time.
    rst_n   = 1'b0;
    pad     = 1'b1;
    stm     = 1'b1;
    bootsel = 1'b0;
    repeat (3) tick();
    push_exp("reset_rstn", 0);
    pop_chk(int'(rstn0));
    push_exp("reset_stm", 0);
    pop_chk(int'(stm0));
    push_exp("reset_bootsel", 0);
    pop_chk(int'(boot0));
    push_exp("reset_state", 0);
    pop_chk(int'(state0));

    push_exp("poweron_release_edges", 15);
    push_exp("nohold_release_edges", 11);
    rst_n = 1'b1;
    r0 = -1;
    r1 = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rstn0 === 1'b1 && r0 < 0) r0 = i;
      if (rstn1 === 1'b1 && r1 < 0) r1 = i;
      // Straps move after capture, while the main instance is still in hold.
      if (i == 12) begin
        stm     = 1'b0;
        bootsel = 1'b1;
      end
      if (r0 > 0 && r1 > 0) break;
    end
    pop_chk(r0);
    pop_chk(r1);

    push_exp("run_state", 4);
    pop_chk(int'(state0));
    push_exp("strap_stm_latched", 1);
    pop_chk(int'(stm0));
    push_exp("strap_bootsel_latched", 0);
    pop_chk(int'(boot0));
    push_exp("nohold_run_state", 4);
    pop_chk(int'(state1));
    push_exp("nohold_stm", 1);
    pop_chk(int'(stm1));
    push_exp("nohold_bootsel", 0);
    pop_chk(int'(boot1));

`ifndef CORE_V_MCU_RST_FAST_ASSERT_EN
    // A 7-cycle low glitch in run must be filtered out.
    push_exp("glitch7_low_edges", 0);
    pad = 1'b0;
    repeat (7) tick();
    pad   = 1'b1;
    highs = 0;
    for (int i = 0; i < 15; i++) begin
      if (rstn0 !== 1'b1) highs++;
      tick();
    end
    pop_chk(highs);
`endif

    // Sustained low: debounced assertion (edge 10), or edge 3 with fast assert.
`ifdef CORE_V_MCU_RST_FAST_ASSERT_EN
    push_exp("run_assert_edges", 3);
`else
    push_exp("run_assert_edges", 10);
`endif
    pad = 1'b0;
    wait_rstn(1'b0, 30, n);
    pop_chk(n);
    push_exp("assert_state", 0);
    pop_chk(int'(state0));
    push_exp("assert_stm_held", 1);
    pop_chk(int'(stm0));
    push_exp("assert_bootsel_held", 0);
    pop_chk(int'(boot0));

    // Bounce: 5 high, 1 low, then high; the count restarts from the final rise.
    push_exp("bounce_release_edges", 15);
    pad = 1'b1;
    repeat (5) tick();
    pad = 1'b0;
    tick();
    pad = 1'b1;
    wait_rstn(1'b1, 40, n);
    pop_chk(n);
    push_exp("recapture_stm", 0);
    pop_chk(int'(stm0));
    push_exp("recapture_bootsel", 1);
    pop_chk(int'(boot0));

    // Back to assert, then drop the pad in hold so the low lands on the terminal hold count.
    pad = 1'b0;
    repeat (12) tick();
    push_exp("reassert_state", 0);
    pop_chk(int'(state0));
    push_exp("hold_entered", 1);
    pad   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state0 === 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    pop_chk(int'(found));
    tick();
    pad = 1'b0;
    push_exp("midhold_assert_edges", 3);
    push_exp("midhold_rstn_high_edges", 0);
    n     = -1;
    highs = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rstn0 !== 1'b0) highs++;
      if (state0 === 3'd0) begin
        n = i;
        break;
      end
    end
    pop_chk(n);
    pop_chk(highs);

    push_exp("midhold_full_release_edges", 15);
    pad = 1'b1;
    wait_rstn(1'b1, 40, n);
    pop_chk(n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
